// File: rtl/mem_scan_master.sv
// rtl/mem_scan_master.sv - block-statistics bus initiator: reads LEN words, writes wrapping sum and signed max back.
module mem_scan_master #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_adr,
    input  logic [ADDR_W-1:0] len,
    input  logic [ADDR_W-1:0] dst_adr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sum_out,
    output logic [DATA_W-1:0] max_out,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] adr,
    output logic [DATA_W-1:0] data_to_mem,
    input  logic [DATA_W-1:0] data_from_mem
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_WR_SUM = 3'd2;
    localparam logic [2:0] S_WR_MAX = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [DATA_W-1:0] MAX_INIT = {1'b1, {(DATA_W-1){1'b0}}};

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] sum_out_q, sum_out_d;
    logic [DATA_W-1:0] max_out_q, max_out_d;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        dst_d     = dst_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        max_d     = max_q;
        sum_out_d = sum_out_q;
        max_out_d = max_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d = base_adr;
                    len_d  = len;
                    dst_d  = dst_adr;
                    idx_d  = '0;
                    sum_d  = '0;
                    max_d  = MAX_INIT;
                    if (len == '0) begin
                        // Empty block reports zeros rather than the max seed value.
                        sum_out_d = '0;
                        max_out_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                sum_d = sum_q + data_from_mem;
                if ($signed(data_from_mem) > $signed(max_q)) begin
                    max_d = data_from_mem;
                end
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == len_q - ADDR_W'(1)) begin
                    state_d = S_WR_SUM;
                end
            end
            S_WR_SUM: state_d = S_WR_MAX;
            S_WR_MAX: begin
                sum_out_d = sum_q;
                max_out_d = max_q;
                state_d   = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            dst_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            max_q     <= '0;
            sum_out_q <= '0;
            max_out_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            dst_q     <= dst_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
            sum_out_q <= sum_out_d;
            max_out_q <= max_out_d;
        end
    end

    // Bus signals decode straight from state so an idle bus is always all-zero.
    always_comb begin
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        adr         = '0;
        data_to_mem = '0;
        case (state_q)
            S_READ: begin
                MemRead = 1'b1;
                adr     = base_q + idx_q;
            end
            S_WR_SUM: begin
                MemWrite    = 1'b1;
                adr         = dst_q;
                data_to_mem = sum_q;
            end
            S_WR_MAX: begin
                MemWrite    = 1'b1;
                adr         = dst_q + ADDR_W'(1);
                data_to_mem = max_q;
            end
            default: ;
        endcase
    end

    assign busy    = (state_q == S_READ) || (state_q == S_WR_SUM) || (state_q == S_WR_MAX);
    assign done    = (state_q == S_DONE);
    assign sum_out = sum_out_q;
    assign max_out = max_out_q;

endmodule

// File: tb/tb_mem_scan_master.sv
// tb/tb_mem_scan_master.sv - directed bench for mem_scan_master with a behavioural 4096x16 memory.
module tb_mem_scan_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] base_adr, len, dst_adr;
    logic        busy, done, MemRead, MemWrite;
    logic [15:0] sum_out, max_out, data_to_mem, data_from_mem;
    logic [11:0] adr;

    logic [15:0] mem [4096];
    int checks = 0;
    int failures = 0;
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, nz_cnt = 0;
    int rd0, wr0, k;

    always #5 clk = ~clk;

    mem_scan_master dut (
        .clk(clk), .rst(rst), .start(start), .base_adr(base_adr), .len(len),
        .dst_adr(dst_adr), .busy(busy), .done(done), .sum_out(sum_out),
        .max_out(max_out), .MemRead(MemRead), .MemWrite(MemWrite), .adr(adr),
        .data_to_mem(data_to_mem), .data_from_mem(data_from_mem)
    );

    assign data_from_mem = MemRead ? mem[adr] : 16'h0;

    always @(posedge clk) begin
        if (MemWrite) mem[adr] <= data_to_mem;
        if (MemRead) rd_cnt <= rd_cnt + 1;
        if (MemWrite) wr_cnt <= wr_cnt + 1;
        if (MemRead && MemWrite) both_cnt <= both_cnt + 1;
        if ((!MemRead && !MemWrite && adr != 12'h0) || (!MemWrite && data_to_mem != 16'h0))
            nz_cnt <= nz_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge of cycle T+1 where T is the accepting edge.
    task automatic launch(input logic [11:0] b, input logic [11:0] l, input logic [11:0] d);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        start = 1'b1; base_adr = b; len = l; dst_adr = d;
        @(negedge clk);
        start = 1'b0; base_adr = 12'h0; len = 12'h0; dst_adr = 12'h0;
        k = 1;
    endtask

    task automatic wait_done(input string tag, input int exp_k);
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, {31'h0, done}, 32'h1);
        check({tag, "_latency"}, k, exp_k);
        check({tag, "_busy_in_done"}, {31'h0, busy}, 32'h0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        rst = 1'b1; start = 1'b0; base_adr = 12'h0; len = 12'h0; dst_adr = 12'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_rdwr", {30'h0, MemRead, MemWrite}, 32'h0);
        check("rst_adr", {20'h0, adr}, 32'h0);
        check("rst_sum", {16'h0, sum_out}, 32'h0);
        check("rst_max", {16'h0, max_out}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Mixed-sign block
        mem[16] = 16'd3; mem[17] = 16'hFFFE; mem[18] = 16'd7; mem[19] = 16'd1;
        launch(12'd16, 12'd4, 12'd100);
        check("t1_busy", {31'h0, busy}, 32'h1);
        check("t1_first_adr", {20'h0, adr}, 32'd16);
        wait_done("t1", 7);
        check("t1_sum", {16'h0, sum_out}, 32'd9);
        check("t1_max", {16'h0, max_out}, 32'd7);
        check("t1_mem100", {16'h0, mem[100]}, 32'd9);
        check("t1_mem101", {16'h0, mem[101]}, 32'd7);
        check("t1_reads", rd_cnt - rd0, 32'd4);
        check("t1_writes", wr_cnt - wr0, 32'd2);

        // Address wrap on reads and on dst+1
        mem[4094] = 16'h7FFF; mem[4095] = 16'h0001; mem[0] = 16'h0002;
        launch(12'd4094, 12'd3, 12'd4095);
        wait_done("t2", 6);
        check("t2_sum", {16'h0, sum_out}, 32'h8002);
        check("t2_max", {16'h0, max_out}, 32'h7FFF);
        check("t2_mem4095", {16'h0, mem[4095]}, 32'h8002);
        check("t2_mem0", {16'h0, mem[0]}, 32'h7FFF);

        // All-negative block
        mem[200] = 16'hFFFB; mem[201] = 16'hFFFD; mem[202] = 16'hFFF7;
        launch(12'd200, 12'd3, 12'd300);
        wait_done("t3", 6);
        check("t3_sum", {16'h0, sum_out}, 32'hFFEF);
        check("t3_max", {16'h0, max_out}, 32'hFFFD);
        check("t3_mem301", {16'h0, mem[301]}, 32'hFFFD);

        // Zero length
        mem[60] = 16'h1234; mem[61] = 16'h5678;
        launch(12'd50, 12'd0, 12'd60);
        wait_done("t4", 1);
        check("t4_sum", {16'h0, sum_out}, 32'h0);
        check("t4_max", {16'h0, max_out}, 32'h0);
        check("t4_reads", rd_cnt - rd0, 32'd0);
        check("t4_writes", wr_cnt - wr0, 32'd0);
        check("t4_mem60", {16'h0, mem[60]}, 32'h1234);
        check("t4_mem61", {16'h0, mem[61]}, 32'h5678);

        // Second start during READ must be ignored
        mem[400] = 16'd10; mem[401] = 16'd20; mem[500] = 16'd1000; mem[700] = 16'hAAAA;
        launch(12'd400, 12'd2, 12'd600);
        start = 1'b1; base_adr = 12'd500; len = 12'd1; dst_adr = 12'd700;
        @(negedge clk);
        k++;
        start = 1'b0; base_adr = 12'h0; len = 12'h0; dst_adr = 12'h0;
        wait_done("t5", 5);
        check("t5_sum", {16'h0, sum_out}, 32'd30);
        check("t5_max", {16'h0, max_out}, 32'd20);
        check("t5_mem600", {16'h0, mem[600]}, 32'd30);
        check("t5_mem601", {16'h0, mem[601]}, 32'd20);
        check("t5_mem700", {16'h0, mem[700]}, 32'hAAAA);
        check("t5_reads", rd_cnt - rd0, 32'd2);

        // Reset during WR_SUM drops the max write
        mem[800] = 16'h5555; mem[801] = 16'h5555;
        launch(12'd16, 12'd4, 12'd800);
        repeat (4) @(negedge clk);
        check("t6_in_wrsum", {31'h0, MemWrite}, 32'h1);
        check("t6_wrsum_adr", {20'h0, adr}, 32'd800);
        rst = 1'b1;
        @(negedge clk);
        check("t6_memwrite_off", {31'h0, MemWrite}, 32'h0);
        check("t6_busy", {31'h0, busy}, 32'h0);
        check("t6_sum", {16'h0, sum_out}, 32'h0);
        check("t6_max", {16'h0, max_out}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_mem801", {16'h0, mem[801]}, 32'h5555);
        launch(12'd16, 12'd4, 12'd900);
        wait_done("t6r", 7);
        check("t6r_sum", {16'h0, sum_out}, 32'd9);
        check("t6r_mem900", {16'h0, mem[900]}, 32'd9);
        check("t6r_mem901", {16'h0, mem[901]}, 32'd7);

        check("bus_rd_wr_overlap", both_cnt, 32'd0);
        check("bus_idle_nonzero", nz_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
